// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator with phase-staggered channels, glitch-free
// period-aligned duty updates, a host write port and a debounced step key.
module pwm_multi_ch #(
    parameter int CH_NUM    = 4,
    parameter int CNT_W     = 20,
    parameter int PERIOD    = 50000,
    parameter int DUTY_INIT = 25000,
    parameter int DUTY_STEP = 10000,
    parameter int DEBOUNCE  = 1000000,
    parameter int PHASE_EN  = 1,
    localparam int CH_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              key_in,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_duty,
    output logic [CH_NUM-1:0] pwm_out,
    output logic              period_end,
    output logic              key_evt
);

    localparam int unsigned OFF_STEP = (PHASE_EN != 0) ? PERIOD / CH_NUM : 0;
    localparam int          DB_W     = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] INIT_C   = CNT_W'(DUTY_INIT);
    localparam logic [CNT_W:0]   PERIOD_W = (CNT_W + 1)'(PERIOD);
    localparam logic [CNT_W:0]   STEP_W   = (CNT_W + 1)'(DUTY_STEP);
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE - 1);

    logic [CNT_W-1:0]  cnt;
    logic              last;
    logic [CNT_W-1:0]  duty_pend [CH_NUM];
    logic [CNT_W-1:0]  duty_act  [CH_NUM];
    logic [CNT_W-1:0]  pend_next [CH_NUM];
    logic [CNT_W-1:0]  wr_clamped;
    logic [CH_NUM-1:0] pwm_next;

    logic              key_s1;
    logic              key_s2;
    logic [DB_W-1:0]   db_cnt;
    logic              released;

    assign last       = (cnt == LAST_C);
    assign wr_clamped = (wr_duty > PERIOD_C) ? PERIOD_C : wr_duty;

    // Phase wrap is a single compare-and-subtract since cnt and offset are both < PERIOD.
    always_comb begin
        logic [CNT_W:0] ph;
        ph       = '0;
        pwm_next = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            ph = {1'b0, cnt} + (CNT_W + 1)'(i * OFF_STEP);
            if (ph >= PERIOD_W) begin
                ph = ph - PERIOD_W;
            end
            pwm_next[i] = (ph < {1'b0, duty_act[i]});
        end
    end

    always_comb begin
        logic [CNT_W:0] step_sum;
        step_sum = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            step_sum     = {1'b0, duty_pend[i]} + STEP_W;
            pend_next[i] = duty_pend[i];
            if (wr_en && (wr_ch == CH_W'(i))) begin
                pend_next[i] = wr_clamped;
            end else if (key_evt) begin
                pend_next[i] = (step_sum > PERIOD_W) ? '0 : step_sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt        <= '0;
            period_end <= 1'b0;
            pwm_out    <= '0;
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                duty_pend[i] <= INIT_C;
                duty_act[i]  <= INIT_C;
            end
        end else begin
            cnt        <= last ? '0 : cnt + 1'b1;
            period_end <= last;
            pwm_out    <= pwm_next;
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                if (last) begin
                    duty_act[i] <= duty_pend[i];
                end
                duty_pend[i] <= pend_next[i];
            end
        end
    end

    // One event per press: re-armed only after the synchronized key is seen high.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            key_s1   <= 1'b1;
            key_s2   <= 1'b1;
            db_cnt   <= '0;
            released <= 1'b1;
            key_evt  <= 1'b0;
        end else begin
            key_s1  <= key_in;
            key_s2  <= key_s1;
            key_evt <= 1'b0;
            if (key_s2) begin
                db_cnt   <= '0;
                released <= 1'b1;
            end else if (db_cnt == DB_MAX) begin
                if (released) begin
                    key_evt  <= 1'b1;
                    released <= 1'b0;
                end
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

endmodule
